// File: rtl/psram_xfer_sched_pkg.sv
// Shared types and constants for the PSRAM request scheduler.
package psram_xfer_sched_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } sched_state_e;

  // A single requester still needs a one-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psram_xfer_sched_rr_arb.sv
// Combinational round-robin picker: first valid index at or after the pointer,
// wrapping modulo NUM_REQ (handles non-power-of-2 counts).
module psram_xfer_sched_rr_arb
  import psram_xfer_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [ptr_width(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [ptr_width(NUM_REQ)-1:0] idx_o,
  output logic                          any_o
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!any_o && valid_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/psram_xfer_sched.sv
// Round-robin scheduler of single-byte read/write requests in front of psram_core,
// with a completion-timeout guard.
//
// state | meaning
// IDLE  | waiting for an enabled, valid request; grants combinationally
// ISSUE | one-cycle start pulse to the core; timeout counter cleared
// WAIT  | waiting for core done or terminal count
// RESP  | one-cycle response pulse to the granted requester; pointer advances
module psram_xfer_sched
  import psram_xfer_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TMO_WIDTH = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        sched_en_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        core_xfer_en_o,
  output logic                        core_we_o,
  output logic [ADDR_W-1:0]           core_addr_o,
  output logic [DATA_W-1:0]           core_wdata_o,
  input  logic                        core_done_i,
  input  logic [DATA_W-1:0]           core_rdata_i,
  output logic                        busy_o
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [TMO_WIDTH-1:0] TMO_MAX = '1;

  sched_state_e         state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [TMO_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_any;

  psram_xfer_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign cnt_inc = cnt_q + TMO_WIDTH'(1);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gidx_d         = gidx_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    req_ready_o    = '0;
    rsp_valid_o    = '0;
    core_xfer_en_o = 1'b0;
    busy_o         = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (sched_en_i && arb_any) begin
          req_ready_o = arb_gnt;
          gidx_d      = arb_idx;
          we_d        = req_we_i[arb_idx];
          addr_d      = req_addr_i[ADDR_W*int'(arb_idx) +: ADDR_W];
          wdata_d     = req_wdata_i[DATA_W*int'(arb_idx) +: DATA_W];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_xfer_en_o = 1'b1;
        cnt_d          = '0;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // Done takes priority over a coincident terminal count.
        if (core_done_i) begin
          rdata_d = we_q ? '0 : core_rdata_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_inc == TMO_MAX) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_o[gidx_q] = 1'b1;
        ptr_d   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign core_we_o    = we_q;
  assign core_addr_o  = addr_q;
  assign core_wdata_o = wdata_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_psram_xfer_sched.sv
// Self-checking bench for psram_xfer_sched: directed cases plus randomized
// transfers checked against a transaction-level model of grant order and response timing.
module tb_psram_xfer_sched;

  localparam int NR  = 3;
  localparam int TW  = 4;
  localparam int TMO = (1 << TW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sched_en;
  logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NR*32-1:0]  req_addr;
  logic [NR*8-1:0]   req_wdata;
  logic [7:0]        rsp_rdata, core_wdata, core_rdata;
  logic              rsp_err, core_xfer_en, core_we, core_done, busy;
  logic [31:0]       core_addr;

  int n_chk = 0;
  int n_bad = 0;
  int ptr_m = 0;

  psram_xfer_sched #(.NUM_REQ(NR), .TMO_WIDTH(TW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .sched_en_i     (sched_en),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .core_xfer_en_o (core_xfer_en),
    .core_we_o      (core_we),
    .core_addr_o    (core_addr),
    .core_wdata_o   (core_wdata),
    .core_done_i    (core_done),
    .core_rdata_i   (core_rdata),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // d: cycle after ISSUE at which core_done pulses (0 = never).
  // drop_c / rst_c: cycle after ISSUE to drop sched_en / pulse reset (0 = never).
  task automatic do_xfer(input logic [NR-1:0] vm, input logic [NR-1:0] we,
                         input logic [NR*32-1:0] ad, input logic [NR*8-1:0] wd,
                         input int d, input logic [7:0] crd,
                         input int drop_c, input int rst_c);
    int            g;
    int            resp_c;
    int            waited;
    logic          err_e;
    logic [7:0]    rd_e;
    logic [NR-1:0] gnt_e;
    bit            aborted;
    g = -1;
    for (int off = 0; off < NR; off++) begin
      int i;
      i = (ptr_m + off) % NR;
      if (g < 0 && vm[i]) g = i;
    end
    if (g < 0) g = 0;
    gnt_e    = '0;
    gnt_e[g] = 1'b1;
    if (d >= 1 && d <= TMO) begin
      resp_c = d + 1;
      err_e  = 1'b0;
      rd_e   = we[g] ? 8'h00 : crd;
    end else begin
      resp_c = TMO + 1;
      err_e  = 1'b1;
      rd_e   = 8'h00;
    end

    sched_en  = 1'b1;
    req_valid = vm;
    req_we    = we;
    req_addr  = ad;
    req_wdata = wd;
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 4) begin
      step();
      waited++;
      #1;
    end
    chk("grant", 32'(req_ready), 32'(gnt_e));
    if (req_ready == '0) begin
      req_valid = '0;
      return;
    end
    chk("busy_accept", 32'(busy), 32'd0);

    step();
    req_valid = '0;
    #1;
    chk("xfer_en", 32'(core_xfer_en), 32'd1);
    chk("core_addr", core_addr, ad[32*g +: 32]);
    chk("core_we", 32'(core_we), 32'(we[g]));
    chk("core_wdata", 32'(core_wdata), 32'(wd[8*g +: 8]));
    chk("busy_issue", 32'(busy), 32'd1);

    aborted = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      core_done  = (c == d);
      core_rdata = (c == d) ? crd : 8'($urandom);
      if (c == drop_c) sched_en = 1'b0;
      if (c == rst_c) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
      end
      if (rst_c > 0 && c == rst_c + 1) rst_n = 1'b1;
      #1;
      chk("xfer_en_low", 32'(core_xfer_en), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), (!aborted && c == resp_c) ? 32'(gnt_e) : 32'd0);
      if (!aborted && c == resp_c) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(rd_e));
        chk("rsp_err", 32'(rsp_err), 32'(err_e));
        chk("addr_stable", core_addr, ad[32*g +: 32]);
        ptr_m = (g + 1) % NR;
      end
      if (!aborted && c > resp_c) begin
        chk("rsp_hold", {23'd0, rsp_err, rsp_rdata}, {23'd0, err_e, rd_e});
        chk("busy_after", 32'(busy), 32'd0);
      end
      if (aborted) chk("busy_rst", 32'(busy), 32'd0);
    end
    if (aborted) ptr_m = 0;
    rst_n     = 1'b1;
    core_done = 1'b0;
    sched_en  = 1'b1;
  endtask

  initial begin
    logic [NR*32-1:0] ad;
    logic [NR*8-1:0]  wd;
    int               d;
    int               rc;

    rst_n      = 1'b0;
    sched_en   = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    core_done  = 1'b0;
    core_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_xfer_en", 32'(core_xfer_en), 32'd0);
    chk("rst_core_addr", core_addr, 32'd0);
    chk("rst_rsp", {23'd0, rsp_err, rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    step();

    // Contention from reset: grants alternate 0,1,0,1; requester 1 writes 0x5C.
    ad = {32'h0, 32'h0000_BEEF, 32'h0000_0100};
    wd = {8'h00, 8'h5C, 8'h11};
    for (int k = 0; k < 4; k++) do_xfer(3'b011, 3'b010, ad, wd, 3 + k, 8'h30 + 8'(k), 0, 0);

    // Single read: done 5 cycles after ISSUE, response at accept+7.
    do_xfer(3'b001, 3'b000, {64'h0, 32'h0000_1234}, 24'h0, 5, 8'hA5, 0, 0);

    // Timeout, then a normal transfer.
    do_xfer(3'b001, 3'b000, {64'h0, 32'h0000_2000}, 24'h0, 0, 8'h00, 0, 0);
    do_xfer(3'b100, 3'b000, {32'h0000_3000, 64'h0}, 24'h0, 2, 8'h77, 0, 0);

    // Done coincides with the terminal count.
    do_xfer(3'b010, 3'b000, {32'h0, 32'h0000_4444, 32'h0}, 24'h0, TMO, 8'hC3, 0, 0);

    // Scheduling disabled: no grant, FSM stays idle.
    sched_en  = 1'b0;
    req_valid = 3'b001;
    for (int k = 0; k < 20; k++) begin
      step();
      #1;
      chk("en_off_ready", 32'(req_ready), 32'd0);
      chk("en_off_busy", 32'(busy), 32'd0);
    end
    do_xfer(3'b001, 3'b001, {64'h0, 32'h0000_5000}, 24'h00_00_9A, 6, 8'h00, 3, 0);

    // Reset mid-WAIT: no response, late done ignored, pointer back to 0.
    do_xfer(3'b001, 3'b000, {64'h0, 32'h0000_6000}, 24'h0, 4, 8'h12, 0, 0);
    do_xfer(3'b010, 3'b000, {32'h0, 32'h0000_7000, 32'h0}, 24'h0, 8, 8'h34, 0, 3);
    do_xfer(3'b111, 3'b000, {32'h3, 32'h2, 32'h0000_8000}, 24'h0, 2, 8'h56, 0, 0);

    for (int k = 0; k < 50; k++) begin
      ad = {$urandom, $urandom, $urandom};
      wd = 24'($urandom);
      d  = int'($urandom_range(0, 18));
      rc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0;
      do_xfer(3'($urandom_range(1, 7)), 3'($urandom), ad, wd, d, 8'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0, rc);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
